// File: rtl/prores_pkg.sv
// prores_pkg: constants and types shared by the DC write path (dc_vlc_to_mem)
// and the DC fetch path. Both sides must agree on the block geometry, so
// neither side should define these values locally.
//   MAX_PIXEL_NUM     : coefficients per block
//   MAX_BLOCK_NUM_DEF : default DC buffer depth (2048-word frame / 64)
//   COEF_IDX_W        : width of the within-block coefficient index
//   dc_wr_state_t     : DC writer FSM states
package prores_pkg;

  localparam int MAX_PIXEL_NUM     = 64;
  localparam int MAX_BLOCK_NUM_DEF = 32;
  localparam int COEF_IDX_W        = $clog2(MAX_PIXEL_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dc_wr_state_t;

  // True when a requested frame does not fit in the DC buffer.
  function automatic logic blk_total_bad(input logic [31:0] total,
                                         input int          max_blocks);
    return total > 32'(max_blocks);
  endfunction

endpackage

// File: rtl/dc_vlc_to_mem_coef_block_counter.sv
// coef_block_counter: per-block beat counter shared by block-oriented
// coefficient consumers. Tracks the coefficient index (mod 64) and the block
// index, and flags the first beat of a block and the final beat of a frame.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   clr_i          : clear both counters (frame start)
//   adv_i          : an accepted coefficient beat
//   blk_total_i    : blocks in the current frame
//   coef_first_o   : current beat is coefficient 0 of a block
//   last_beat_o    : current beat is coefficient 63 of the final block
//   blk_addr_o     : block index truncated to the buffer address width
module coef_block_counter
  import prores_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TOTAL_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [TOTAL_W-1:0] blk_total_i,
  output logic               coef_first_o,
  output logic               last_beat_o,
  output logic [ADDR_W-1:0]  blk_addr_o
);

  // One extra bit on the block index so a full buffer does not alias to 0.
  localparam int BLK_W = ADDR_W + 1;
  localparam logic [COEF_IDX_W-1:0] COEF_LAST = COEF_IDX_W'(MAX_PIXEL_NUM - 1);

  logic [COEF_IDX_W-1:0] coef_idx_q, coef_idx_d;
  logic [BLK_W-1:0]      blk_idx_q, blk_idx_d;
  logic [TOTAL_W-1:0]    blk_final;
  logic                  coef_last;

  assign coef_first_o = (coef_idx_q == '0);
  assign coef_last    = (coef_idx_q == COEF_LAST);
  assign blk_final    = blk_total_i - TOTAL_W'(1);
  assign last_beat_o  = coef_last && (TOTAL_W'(blk_idx_q) == blk_final);
  assign blk_addr_o   = blk_idx_q[ADDR_W-1:0];

  always_comb begin
    coef_idx_d = coef_idx_q;
    blk_idx_d  = blk_idx_q;
    if (clr_i) begin
      coef_idx_d = '0;
      blk_idx_d  = '0;
    end else if (adv_i) begin
      coef_idx_d = coef_idx_q + COEF_IDX_W'(1);
      if (coef_last) begin
        blk_idx_d = blk_idx_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      coef_idx_q <= '0;
      blk_idx_q  <= '0;
    end else begin
      coef_idx_q <= coef_idx_d;
      blk_idx_q  <= blk_idx_d;
    end
  end

endmodule

// File: rtl/dc_vlc_to_mem.sv
// dc_vlc_to_mem: picks the DC (coefficient 0) out of a 64-per-block
// quantised coefficient stream and writes it to a dense DC buffer at
// word address = block index.
// Build option: define DC_DIFF_EN to write DC[n] - DC[n-1] (block 0 raw)
// instead of the raw DC.
// Ports:
//   clock, reset_n   : clock, async active-low reset
//   start, block_num : frame start pulse (IDLE only) and block count
//   in_valid/in_data : coefficient stream; in_ready high only in RUN
//   wr_en/addr/data  : registered DC buffer write port
//   busy             : RUN or DONE
//   done             : one-cycle frame end pulse
//   err              : sticky, block_num exceeded the buffer depth
//
// state | meaning
// IDLE  | waiting for start; also hosts the one-cycle skip for empty/bad frames
// RUN   | accepting coefficients, writing one DC per block
// DONE  | done pulse, back to IDLE next cycle
module dc_vlc_to_mem
  import prores_pkg::*;
#(
  parameter int MAX_BLOCK_NUM = MAX_BLOCK_NUM_DEF,
  parameter int DATA_W        = 32
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [31:0]                      block_num,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [$clog2(MAX_BLOCK_NUM)-1:0] wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int ADDR_W = $clog2(MAX_BLOCK_NUM);

  dc_wr_state_t      state_q, state_d;
  logic [31:0]       blk_total_q, blk_total_d;
  logic              err_q, err_d;
  logic              skip_q, skip_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              frame_start;
  logic              beat;
  logic              dc_write;
  logic              coef_first;
  logic              last_beat;
  logic [ADDR_W-1:0] blk_addr;
  logic [DATA_W-1:0] dc_word;

  // skip_q blocks a second start while an empty/oversized frame is being
  // retired, so such a frame still answers with done two cycles after start.
  assign frame_start = (state_q == IDLE) && !skip_q && start;
  assign beat        = (state_q == RUN) && in_valid;
  assign dc_write    = beat && coef_first;

  coef_block_counter #(
    .ADDR_W  (ADDR_W),
    .TOTAL_W (32)
  ) u_cnt (
    .clock        (clock),
    .reset_n      (reset_n),
    .clr_i        (frame_start),
    .adv_i        (beat),
    .blk_total_i  (blk_total_q),
    .coef_first_o (coef_first),
    .last_beat_o  (last_beat),
    .blk_addr_o   (blk_addr)
  );

`ifdef DC_DIFF_EN
  logic [DATA_W-1:0] prev_dc_q, prev_dc_d;

  always_comb begin
    prev_dc_d = prev_dc_q;
    if (frame_start) begin
      prev_dc_d = '0;
    end else if (dc_write) begin
      prev_dc_d = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_dc_q <= '0;
    end else begin
      prev_dc_q <= prev_dc_d;
    end
  end

  // prev_dc is zero for block 0, so the same subtract yields the raw DC there.
  assign dc_word = in_data - prev_dc_q;
`else
  assign dc_word = in_data;
`endif

  always_comb begin
    state_d     = state_q;
    blk_total_d = blk_total_q;
    err_d       = err_q;
    skip_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (skip_q) begin
          state_d = DONE;
        end else if (frame_start) begin
          blk_total_d = block_num;
          err_d       = blk_total_bad(block_num, MAX_BLOCK_NUM);
          if (block_num == 32'd0 || blk_total_bad(block_num, MAX_BLOCK_NUM)) begin
            skip_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (dc_write) begin
          wr_en_d   = 1'b1;
          wr_addr_d = blk_addr;
          wr_data_d = dc_word;
        end
        if (beat && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      blk_total_q <= '0;
      err_q       <= 1'b0;
      skip_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      blk_total_q <= blk_total_d;
      err_q       <= err_d;
      skip_q      <= skip_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_dc_vlc_to_mem.sv
module tb_dc_vlc_to_mem;

  localparam int MAXB = 32;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b1;
  logic          start     = 1'b0;
  logic [31:0]   block_num = '0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int done_count = 0;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] dcs[$];

  always #5 clock = ~clock;

  dc_vlc_to_mem #(.MAX_BLOCK_NUM(MAXB), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .block_num (block_num),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: DC buffer word for block b of the frame described by dcs.
  function automatic logic [DW-1:0] exp_word(input int b);
`ifdef DC_DIFF_EN
    if (b == 0) return dcs[0];
    return dcs[b] - dcs[b-1];
`else
    return dcs[b];
`endif
  endfunction

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clock) begin : mon
    wr_t e;
    if (reset_n && wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_write: got addr %0d data %0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (done === 1'b1) done_count++;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got %0d tests", tests);
    $fatal(1, "timeout");
  end

  task automatic set_rand_dcs(input int n);
    dcs.delete();
    repeat (n) dcs.push_back($urandom);
  endtask

  // Entered at posedge+1; leaves at posedge+1 of the first cycle after start.
  task automatic start_frame(input int n);
    start = 1'b1;
    block_num = 32'(n);
    @(negedge clock);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Drives one frame of nblk blocks. Returns early (in_valid low) at stop_beat.
  task automatic send_frame(input int nblk, input int gap_pct, input bit patt,
                            input int stop_beat, input bit inject_start);
    int beat;
    int ns;
    beat = 0;
    for (int b = 0; b < nblk; b++) begin
      for (int c = 0; c < 64; c++) begin
        if (beat == stop_beat) begin
          in_valid = 1'b0;
          return;
        end
        ns = 0;
        if (gap_pct > 0) begin
          if ($urandom_range(99) < gap_pct) ns = $urandom_range(1, 3);
          if (c == 0 || c == 63) ns += 2;
        end
        in_valid = 1'b0;
        repeat (ns) begin
          @(posedge clock);
          #1;
        end
        in_valid = 1'b1;
        in_data  = (c == 0) ? dcs[b] : (patt ? 32'(100 * b + c) : $urandom);
        if (c == 0) exp_q.push_back('{b, exp_word(b)});
        if (inject_start && b == 1 && c == 5) begin
          start = 1'b1;
          block_num = 32'd2;
        end
        @(negedge clock);
        chk("in_ready", 64'(in_ready), 64'd1);
        chk("busy_run", 64'(busy), 64'd1);
        if (beat == 0) chk("err_run", 64'(err), 64'd0);
        @(posedge clock);
        #1;
        start = 1'b0;
        beat++;
      end
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("done_pulse", 64'(done), 64'd1);
    chk("ready_drop", 64'(in_ready), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
  endtask

  task automatic run_frame(input int n, input int gap_pct, input bit patt, input bit inject_start);
    int w0;
    int d0;
    w0 = wr_count;
    d0 = done_count;
    start_frame(n);
    send_frame(n, gap_pct, patt, -1, inject_start);
    @(posedge clock);
    #1;
    chk("write_count", 64'(wr_count - w0), 64'(n));
    chk("done_count", 64'(done_count - d0), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_short(input int n, input bit exp_err);
    int w0;
    int d0;
    w0 = wr_count;
    d0 = done_count;
    start_frame(n);
    @(negedge clock);
    chk("short_done_early", 64'(done), 64'd0);
    chk("short_ready", 64'(in_ready), 64'd0);
    chk("short_err", 64'(err), 64'(exp_err));
    @(negedge clock);
    chk("short_done", 64'(done), 64'd1);
    chk("short_ready2", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    chk("short_writes", 64'(wr_count - w0), 64'd0);
    chk("short_done_count", 64'(done_count - d0), 64'd1);
    chk("short_err_hold", 64'(err), 64'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_wr_en"},    64'(wr_en),    64'd0);
    chk({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
    chk({tag, "_wr_data"},  64'(wr_data),  64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_err"},      64'(err),      64'd0);
  endtask

  initial begin
    int d0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Raw pattern frame: DCs 0,100,200.
    dcs = {32'd0, 32'd100, 32'd200};
    run_frame(3, 0, 1'b1, 1'b0);

    // Negative difference case.
    dcs = {32'd500, 32'd20};
    run_frame(2, 0, 1'b0, 1'b0);

    // Same pattern frame with ~50% gaps and forced stalls at coef 0 and 63.
    dcs = {32'd0, 32'd100, 32'd200};
    run_frame(3, 50, 1'b1, 1'b0);

    // Empty frame, oversized frame, then a good frame clears err.
    run_short(0, 1'b0);
    run_short(33, 1'b1);
    set_rand_dcs(1);
    run_frame(1, 0, 1'b0, 1'b0);
    chk("err_cleared", 64'(err), 64'd0);

    // Reset at block 1, coef 10 of a 4-block frame.
    set_rand_dcs(4);
    d0 = done_count;
    start_frame(4);
    send_frame(4, 0, 1'b0, 64 + 10, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("midreset_no_done", 64'(done_count - d0), 64'd0);
    set_rand_dcs(4);
    run_frame(4, 20, 1'b0, 1'b0);

    // start pulsed mid-frame is ignored.
    set_rand_dcs(3);
    run_frame(3, 30, 1'b0, 1'b1);

    // Back-to-back frames, second start the cycle after done.
    set_rand_dcs(2);
    run_frame(2, 0, 1'b0, 1'b0);
    set_rand_dcs(3);
    run_frame(3, 0, 1'b0, 1'b0);

    // Full buffer: no aliasing at the top address.
    set_rand_dcs(MAXB);
    run_frame(MAXB, 25, 1'b0, 1'b0);

    // Random frames.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 8);
      set_rand_dcs(n);
      run_frame(n, $urandom_range(0, 60), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
